// File: rtl/i2s_clk_gen.sv
// I2S BCLK/LRCK generator with frame-aligned, muted format switching.
// Optional master clock output enabled by defining I2S_MCLK_EN.
module i2s_clk_gen #(
   parameter int HALF_BASE   = 2,
   parameter int MUTE_CYCLES = 16
`ifdef I2S_MCLK_EN
   ,
   parameter int MCLK_MULT   = 4
`endif
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [2:0] clk_sel,
   output logic       bclk,
   output logic       lrck,
   output logic       bit_strobe,
   output logic       frame_start,
   output logic [2:0] active_sel,
   output logic       switching,
`ifdef I2S_MCLK_EN
   output logic       mclk,
`endif
   output logic       sel_err
);

   localparam int HW = $clog2(HALF_BASE + 1) + 5;
   localparam int MW = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;

   typedef enum logic [1:0] {RUN, DRAIN, MUTE} state_t;

   state_t          state;
   logic [HW-1:0]   hc;
   logic [HW-1:0]   half;
   logic [HW-1:0]   last;
   logic [5:0]      bc;
   logic [5:0]      bc_next;
   logic [MW-1:0]   mc;
   logic [2:0]      pending;
   logic            toggle;
   logic            fall;

   assign half    = HW'(HALF_BASE) << active_sel;
   assign last    = half - HW'(1);
   assign bc_next = bc + 6'd1;
   assign toggle  = (hc == last);
   assign fall    = toggle && bclk;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= RUN;
         hc          <= '0;
         bc          <= '0;
         mc          <= '0;
         pending     <= '0;
         bclk        <= 1'b0;
         lrck        <= 1'b0;
         bit_strobe  <= 1'b0;
         frame_start <= 1'b0;
         active_sel  <= '0;
         switching   <= 1'b0;
         sel_err     <= 1'b0;
      end else begin
         bit_strobe  <= 1'b0;
         frame_start <= 1'b0;
         sel_err     <= (clk_sel > 3'd4);
         if (clk_sel <= 3'd4) pending <= clk_sel;

         case (state)
            RUN, DRAIN: begin
               if (toggle) begin
                  hc   <= '0;
                  bclk <= ~bclk;
                  if (bclk) begin
                     bc          <= bc_next;
                     lrck        <= bc_next[5];
                     bit_strobe  <= 1'b1;
                     frame_start <= (bc == 6'd63);
                  end
               end else begin
                  hc <= hc + HW'(1);
               end
               // DRAIN leaves only on the wrap edge, so the last frame is always whole
               if (state == RUN) begin
                  if (pending != active_sel) begin
                     state     <= DRAIN;
                     switching <= 1'b1;
                  end
               end else if (fall && bc == 6'd63) begin
                  if (pending == active_sel) begin
                     state     <= RUN;
                     switching <= 1'b0;
                  end else begin
                     state <= MUTE;
                     mc    <= '0;
                  end
               end
            end
            MUTE: begin
               bclk <= 1'b0;
               lrck <= 1'b0;
               bc   <= '0;
               hc   <= '0;
               if (mc == MW'(MUTE_CYCLES - 1)) begin
                  active_sel <= pending;
                  state      <= RUN;
                  switching  <= 1'b0;
               end else begin
                  mc <= mc + MW'(1);
               end
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef I2S_MCLK_EN
   logic [HW-1:0] mcnt;
   logic [HW-1:0] mq;
   logic [HW-1:0] mdiv;

   assign mq   = half / HW'(MCLK_MULT);
   assign mdiv = (mq == '0) ? HW'(1) : mq;

   // A BCLK rise re-phases mclk so both rise on the same clk
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mclk <= 1'b0;
         mcnt <= '0;
      end else if (state == MUTE) begin
         mclk <= 1'b0;
         mcnt <= '0;
      end else if (toggle && !bclk) begin
         mclk <= 1'b1;
         mcnt <= '0;
      end else if (mcnt == mdiv - HW'(1)) begin
         mclk <= ~mclk;
         mcnt <= '0;
      end else begin
         mcnt <= mcnt + HW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_i2s_clk_gen.sv
// Scoreboard bench for i2s_clk_gen: expected strobe cycles/frame/lrck are
// queued when stimulus is applied and compared on every bit_strobe.
module tb_i2s_clk_gen;

   logic       clk;
   logic       nrst;
   logic [2:0] clk_sel;
   logic       bclk;
   logic       lrck;
   logic       bit_strobe;
   logic       frame_start;
   logic [2:0] active_sel;
   logic       switching;
   logic       sel_err;

   i2s_clk_gen #(.HALF_BASE(2), .MUTE_CYCLES(16)) dut (
      .clk(clk),
      .nrst(nrst),
      .clk_sel(clk_sel),
      .bclk(bclk),
      .lrck(lrck),
      .bit_strobe(bit_strobe),
      .frame_start(frame_start),
      .active_sel(active_sel),
      .switching(switching),
      .sel_err(sel_err)
   );

   typedef struct {
      int unsigned cyc;
      logic        fs;
      logic        lr;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc;
   int unsigned n_cmp;
   int unsigned n_bad;
   int unsigned r;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Strobe monitor: every bit_strobe must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missed_strobe: expected strobe at cycle %0d, absent by cycle %0d", e.cyc, cyc);
      end
      if (frame_start && !bit_strobe) begin
         n_cmp++;
         n_bad++;
         $display("FAIL frame_without_strobe: frame_start=1 bit_strobe=0 at cycle %0d", cyc);
      end
      if (bit_strobe) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_strobe: strobe at cycle %0d fs=%0b lr=%0b, none expected", cyc, frame_start, lrck);
         end else begin
            e = sb.pop_front();
            if ({cyc, frame_start, lrck} !== {e.cyc, e.fs, e.lr}) begin
               n_bad++;
               $display("FAIL strobe: got cycle %0d fs=%0b lr=%0b, expected cycle %0d fs=%0b lr=%0b",
                        cyc, frame_start, lrck, e.cyc, e.fs, e.lr);
            end
         end
      end
   end

   // Expected strobes k0..k1 of a run with BCLK period per, counted from base
   task automatic push_run(input int unsigned base, input int unsigned per,
                           input int unsigned k0, input int unsigned k1);
      exp_t e;
      for (int unsigned k = k0; k <= k1; k++) begin
         e.cyc = base + per * k;
         e.fs  = ((k % 64) == 0);
         e.lr  = ((k % 64) >= 32);
         sb.push_back(e);
      end
   endtask

   task automatic wait_until(input int unsigned c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_reset(input logic [2:0] sel);
      @(negedge clk);
      nrst    = 1'b0;
      clk_sel = sel;
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      r    = cyc;
   endtask

   task automatic check_drained(input string name);
      n_cmp++;
      if (sb.size() !== 0) begin
         n_bad++;
         $display("FAIL %s_drained: %0d expected strobes outstanding, required 0", name, sb.size());
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      nrst    = 1'b0;
      clk_sel = 3'd0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({bclk, lrck, bit_strobe, frame_start, active_sel, switching, sel_err} !== 9'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got bclk=%0b lrck=%0b bs=%0b fs=%0b act=%0d sw=%0b err=%0b, required all 0",
                  bclk, lrck, bit_strobe, frame_start, active_sel, switching, sel_err);
      end
   endtask

   task automatic test_basic;
      logic [3:0] exp_b;
      logic [3:0] got_b;
      do_reset(3'd0);
      push_run(r, 4, 1, 70);
      exp_b = 4'b0110;
      for (int unsigned i = 0; i < 4; i++) begin
         wait_until(r + 1 + i);
         got_b[3 - i] = bclk;
      end
      n_cmp++;
      if (got_b !== exp_b) begin
         n_bad++;
         $display("FAIL basic_first_rise: bclk at cycles 1..4 = %b, required %b", got_b, exp_b);
      end
      wait_until(r + 4 * 70 + 2);
      check_drained("basic");
      n_cmp++;
      if ({active_sel, switching} !== 4'd0) begin
         n_bad++;
         $display("FAIL basic_state: act=%0d sw=%0b, required act=0 sw=0", active_sel, switching);
      end
   endtask

   task automatic test_switch;
      int unsigned low_bad;
      do_reset(3'd0);
      push_run(r, 4, 1, 64);
      wait_until(r + 42);
      clk_sel = 3'd2;
      wait_until(r + 45);
      n_cmp++;
      if (switching !== 1'b1) begin
         n_bad++;
         $display("FAIL switch_flag: switching=%0b, required 1", switching);
      end
      low_bad = 0;
      for (int unsigned c = r + 257; c <= r + 279; c++) begin
         wait_until(c);
         if (bclk !== 1'b0 || lrck !== 1'b0) low_bad++;
         if (c == r + 271) begin
            n_cmp++;
            if ({active_sel, switching} !== {3'd0, 1'b1}) begin
               n_bad++;
               $display("FAIL switch_mute_end: act=%0d sw=%0b, required act=0 sw=1", active_sel, switching);
            end
         end
         if (c == r + 272) begin
            n_cmp++;
            if ({active_sel, switching} !== {3'd2, 1'b0}) begin
               n_bad++;
               $display("FAIL switch_exit: act=%0d sw=%0b, required act=2 sw=0", active_sel, switching);
            end
            push_run(r + 272, 16, 1, 64);
         end
      end
      n_cmp++;
      if (low_bad !== 0) begin
         n_bad++;
         $display("FAIL switch_mute_low: %0d cycles with bclk/lrck high in gap, required 0", low_bad);
      end
      wait_until(r + 280);
      n_cmp++;
      if (bclk !== 1'b1) begin
         n_bad++;
         $display("FAIL switch_new_rise: bclk=%0b 8 clk after mute, required 1", bclk);
      end
      wait_until(r + 272 + 1024 + 2);
      check_drained("switch");
   endtask

   task automatic test_withdraw;
      do_reset(3'd0);
      push_run(r, 4, 1, 80);
      wait_until(r + 42);
      clk_sel = 3'd3;
      wait_until(r + 82);
      clk_sel = 3'd0;
      wait_until(r + 100);
      n_cmp++;
      if (switching !== 1'b1) begin
         n_bad++;
         $display("FAIL withdraw_drain: switching=%0b, required 1", switching);
      end
      wait_until(r + 257);
      n_cmp++;
      if ({active_sel, switching} !== 4'd0) begin
         n_bad++;
         $display("FAIL withdraw_exit: act=%0d sw=%0b, required act=0 sw=0", active_sel, switching);
      end
      wait_until(r + 4 * 80 + 2);
      check_drained("withdraw");
   endtask

   task automatic test_sel_err;
      do_reset(3'd0);
      push_run(r, 4, 1, 64);
      wait_until(r + 10);
      clk_sel = 3'd6;
      wait_until(r + 11);
      n_cmp++;
      if (sel_err !== 1'b1) begin
         n_bad++;
         $display("FAIL sel_err_set: sel_err=%0b, required 1", sel_err);
      end
      wait_until(r + 20);
      n_cmp++;
      if ({active_sel, switching} !== 4'd0) begin
         n_bad++;
         $display("FAIL sel_err_ignored: act=%0d sw=%0b, required act=0 sw=0", active_sel, switching);
      end
      wait_until(r + 30);
      clk_sel = 3'd1;
      wait_until(r + 31);
      n_cmp++;
      if (sel_err !== 1'b0) begin
         n_bad++;
         $display("FAIL sel_err_clear: sel_err=%0b, required 0", sel_err);
      end
      wait_until(r + 272);
      n_cmp++;
      if (active_sel !== 3'd1) begin
         n_bad++;
         $display("FAIL sel_err_switch: act=%0d, required 1", active_sel);
      end
      push_run(r + 272, 8, 1, 10);
      wait_until(r + 272 + 80 + 2);
      check_drained("sel_err");
   endtask

   task automatic test_mute_change;
      do_reset(3'd0);
      push_run(r, 4, 1, 64);
      wait_until(r + 42);
      clk_sel = 3'd1;
      wait_until(r + 262);
      clk_sel = 3'd4;
      wait_until(r + 272);
      n_cmp++;
      if (active_sel !== 3'd4) begin
         n_bad++;
         $display("FAIL mute_change_sel: act=%0d, required 4", active_sel);
      end
      push_run(r + 272, 64, 1, 3);
      wait_until(r + 272 + 192 + 2);
      check_drained("mute_change");
   endtask

   task automatic test_reset_mid_drain;
      do_reset(3'd0);
      push_run(r, 4, 1, 40);
      wait_until(r + 42);
      clk_sel = 3'd2;
      wait_until(r + 162);
      n_cmp++;
      if (switching !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_drain_state: switching=%0b, required 1", switching);
      end
      nrst = 1'b0;
      #1;
      n_cmp++;
      if ({bclk, lrck, bit_strobe, frame_start, active_sel, switching, sel_err} !== 9'd0) begin
         n_bad++;
         $display("FAIL mid_drain_reset: bclk=%0b lrck=%0b bs=%0b fs=%0b act=%0d sw=%0b err=%0b, required all 0",
                  bclk, lrck, bit_strobe, frame_start, active_sel, switching, sel_err);
      end
      check_drained("mid_drain");
      do_reset(3'd0);
      push_run(r, 4, 1, 20);
      wait_until(r + 4 * 20 + 2);
      check_drained("after_reset");
      n_cmp++;
      if ({active_sel, switching} !== 4'd0) begin
         n_bad++;
         $display("FAIL after_reset_state: act=%0d sw=%0b, required act=0 sw=0", active_sel, switching);
      end
   endtask

   initial begin
      cyc     = 0;
      n_cmp   = 0;
      n_bad   = 0;
      nrst    = 1'b0;
      clk_sel = 3'd0;
      test_reset;
      test_basic;
      test_switch;
      test_withdraw;
      test_sel_err;
      test_mute_change;
      test_reset_mid_drain;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
